// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer write arbiter.
package fb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int FB_DATA_WIDTH = 16;
  localparam int FB_BRAM_DEPTH = 230400;
  localparam int FB_BURST_LEN  = 16;

  function automatic int region_end(input int base, input int size);
    return base + size - 1;
  endfunction
endpackage

// File: rtl/fb_region_counter.sv
// Write address for one frame-buffer region: counts base..base+size-1 and wraps to base.
// o_last flags the region-end address so the writer can report frame completion.
module fb_region_counter
  import fb_pkg::*;
#(
  parameter int AW   = 18,
  parameter int BASE = 0,
  parameter int SIZE = 115200
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);
  localparam logic [AW-1:0] LP_BASE = AW'(BASE);
  localparam logic [AW-1:0] LP_END  = AW'(region_end(BASE, SIZE));

  logic [AW-1:0] r_addr;

  assign o_addr = r_addr;
  assign o_last = (r_addr == LP_END);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= LP_BASE;
    end else if (i_clr) begin
      r_addr <= LP_BASE;
    end else if (i_adv) begin
      r_addr <= o_last ? LP_BASE : r_addr + AW'(1);
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter draining two FWFT FIFOs into the two halves of a frame-buffer BRAM.
// Pops are combinational from state; each popped word is written exactly one cycle later.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter  int DATA_WIDTH = FB_DATA_WIDTH,
  parameter  int BRAM_DEPTH = FB_BRAM_DEPTH,
  parameter  int BURST_LEN  = FB_BURST_LEN,
  localparam int AW         = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_almostempty0,
  input  logic                  i_almostempty1,
  input  logic [DATA_WIDTH-1:0] i_rdata0,
  input  logic [DATA_WIDTH-1:0] i_rdata1,
  output logic                  o_rd0,
  output logic                  o_rd1,
  output logic                  o_mem_wr,
  output logic [AW-1:0]         o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [1:0]            o_grant,
  output logic                  o_frame_done0,
  output logic                  o_frame_done1
);
  localparam int HALF = BRAM_DEPTH / 2;
  localparam int BW   = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] LP_BEAT_LAST = BW'(BURST_LEN - 1);

  state_t          r_state;
  logic [BW-1:0]   r_beat;
  logic            r_last_grant;
  logic            w_rd0, w_rd1;
  logic [AW-1:0]   w_addr0, w_addr1;
  logic            w_last0, w_last1;

  // Async reset forces IDLE, so the pop strobes fall without waiting for an edge.
  assign w_rd0 = (r_state == GRANT0) && !i_almostempty0;
  assign w_rd1 = (r_state == GRANT1) && !i_almostempty1;
  assign o_rd0 = w_rd0;
  assign o_rd1 = w_rd1;

  fb_region_counter #(.AW(AW), .BASE(0), .SIZE(HALF)) u_region0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_flush),
    .i_adv  (w_rd0),
    .o_addr (w_addr0),
    .o_last (w_last0)
  );

  fb_region_counter #(.AW(AW), .BASE(HALF), .SIZE(HALF)) u_region1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_flush),
    .i_adv  (w_rd1),
    .o_addr (w_addr1),
    .o_last (w_last1)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_last_grant <= 1'b1;
      o_grant      <= 2'b00;
    end else if (i_flush) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_last_grant <= 1'b1;
      o_grant      <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          // r_last_grant holds the index last served; ties go to the other one.
          if (!i_almostempty0 && (i_almostempty1 || r_last_grant)) begin
            r_state      <= GRANT0;
            o_grant      <= 2'b01;
            r_last_grant <= 1'b0;
            r_beat       <= '0;
          end else if (!i_almostempty1) begin
            r_state      <= GRANT1;
            o_grant      <= 2'b10;
            r_last_grant <= 1'b1;
            r_beat       <= '0;
          end
        end
        GRANT0: begin
          if (i_almostempty0 || (r_beat == LP_BEAT_LAST)) begin
            r_state <= IDLE;
            o_grant <= 2'b00;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        GRANT1: begin
          if (i_almostempty1 || (r_beat == LP_BEAT_LAST)) begin
            r_state <= IDLE;
            o_grant <= 2'b00;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_wr      <= 1'b0;
      o_mem_waddr   <= '0;
      o_mem_wdata   <= '0;
      o_frame_done0 <= 1'b0;
      o_frame_done1 <= 1'b0;
    end else if (i_flush) begin
      o_mem_wr      <= 1'b0;
      o_mem_waddr   <= '0;
      o_mem_wdata   <= '0;
      o_frame_done0 <= 1'b0;
      o_frame_done1 <= 1'b0;
    end else begin
      o_mem_wr      <= w_rd0 | w_rd1;
      o_frame_done0 <= w_rd0 & w_last0;
      o_frame_done1 <= w_rd1 & w_last1;
      if (w_rd0) begin
        o_mem_waddr <= w_addr0;
        o_mem_wdata <= i_rdata0;
      end else if (w_rd1) begin
        o_mem_waddr <= w_addr1;
        o_mem_wdata <= i_rdata1;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised bench for fb_write_arbiter: FIFO queues, write scoreboard and arbitration rule checks.
module tb_fb_write_arbiter;
  localparam int DW    = 16;
  localparam int DEPTH = 128;
  localparam int BL    = 16;
  localparam int HALF  = DEPTH / 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          ae0 = 1'b1, ae1 = 1'b1;
  logic [DW-1:0] rdata0 = '0, rdata1 = '0;
  logic          rd0, rd1, mem_wr, fd0, fd1;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  fb_write_arbiter #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_almostempty0 (ae0),
    .i_almostempty1 (ae1),
    .i_rdata0       (rdata0),
    .i_rdata1       (rdata1),
    .o_rd0          (rd0),
    .o_rd1          (rd1),
    .o_mem_wr       (mem_wr),
    .o_mem_waddr    (waddr),
    .o_mem_wdata    (wdata),
    .o_grant        (grant),
    .o_frame_done0  (fd0),
    .o_frame_done1  (fd1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO contents and reference model state
  logic [DW-1:0] q0[$], q1[$];
  int gen0 = 0, gen1 = 0;
  bit hold0 = 0, hold1 = 0;
  int n_wr[2];
  bit pend_vld = 0;
  int pend_reg, pend_addr;
  logic [DW-1:0] pend_dat;
  bit pend_last;
  int cur_len = 0;
  logic [1:0] prev_grant = 2'b00;
  int wait_c[2];
  int pops[2], writes[2], lost[2], fd_cnt[2];
  int b_owner[$], b_len[$];
  logic s_rd0, s_wr;
  logic [1:0] s_grant;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic push0(input int n);
    for (int i = 0; i < n; i++) begin q0.push_back(DW'(32'hA000 + gen0)); gen0++; end
  endtask

  task automatic push1(input int n);
    for (int i = 0; i < n; i++) begin q1.push_back(DW'(32'hB000 + gen1)); gen1++; end
  endtask

  task automatic drive_inputs();
    ae0    = (q0.size() == 0) || hold0;
    ae1    = (q1.size() == 0) || hold1;
    rdata0 = (q0.size() != 0) ? q0[0] : '0;
    rdata1 = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic model_reset();
    if (pend_vld) lost[pend_reg]++;
    pend_vld   = 0;
    n_wr[0]    = 0; n_wr[1] = 0;
    wait_c[0]  = 0; wait_c[1] = 0;
    cur_len    = 0;
    prev_grant = 2'b00;
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic step();
    bit p0, p1;
    logic [DW-1:0] d0, d1;
    int k;
    @(negedge clk);
    s_rd0 = rd0; s_wr = mem_wr; s_grant = grant;
    chk("wr", mem_wr, pend_vld);
    if (pend_vld) begin
      chk("waddr", waddr, pend_addr);
      chk("wdata", wdata, pend_dat);
      chk("fdone", {fd1, fd0}, pend_last ? (pend_reg ? 2'b10 : 2'b01) : 2'b00);
    end else begin
      chk("fdone_idle", {fd1, fd0}, 2'b00);
    end
    if (mem_wr) writes[(int'(waddr) >= HALF) ? 1 : 0]++;
    fd_cnt[0] += fd0; fd_cnt[1] += fd1;
    chk("rd0", rd0, (grant == 2'b01) && !ae0);
    chk("rd1", rd1, (grant == 2'b10) && !ae1);
    chk("rd_excl", rd0 & rd1, 0);
    if (prev_grant != 2'b00 && grant != 2'b00) chk("gap", grant, prev_grant);
    if (grant != 2'b00) begin
      if (prev_grant == 2'b00) cur_len = 0;
      if (rd0 | rd1) cur_len++;
      chk("burst_max", cur_len <= BL, 1);
    end else if (prev_grant != 2'b00) begin
      b_owner.push_back((prev_grant == 2'b10) ? 1 : 0);
      b_len.push_back(cur_len);
    end
    prev_grant = grant;
    if (!ae0 && grant != 2'b01) wait_c[0]++; else wait_c[0] = 0;
    if (!ae1 && grant != 2'b10) wait_c[1]++; else wait_c[1] = 0;
    chk("starve0", wait_c[0] <= BL + 2, 1);
    chk("starve1", wait_c[1] <= BL + 2, 1);
    p0 = rd0; p1 = rd1; d0 = rdata0; d1 = rdata1;
    @(posedge clk);
    #1;
    pend_vld = 0;
    if (p0) begin void'(q0.pop_front()); pops[0]++; end
    if (p1) begin void'(q1.pop_front()); pops[1]++; end
    if (flush) begin
      lost[0] += p0; lost[1] += p1;
      n_wr[0] = 0; n_wr[1] = 0;
      wait_c[0] = 0; wait_c[1] = 0;
    end else if (p0 || p1) begin
      k         = p1 ? 1 : 0;
      pend_vld  = 1;
      pend_reg  = k;
      pend_addr = k * HALF + (n_wr[k] % HALF);
      pend_last = (n_wr[k] % HALF) == HALF - 1;
      pend_dat  = p1 ? d1 : d0;
      n_wr[k]++;
    end
    flush = 1'b0;
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    hold0 = 0; hold1 = 0; flush = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b_owner.delete(); b_len.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, f1, w1;
    drive_inputs();
    #12;
    chk("rst_wr", mem_wr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_fdone", {fd1, fd0}, 0);
    chk("rst_rd", {rd1, rd0}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both FIFOs continuously ready: alternating full bursts, requester 0 first.
    apply_reset();
    push0(40); push1(40); drive_inputs();
    repeat (60) step();
    chk("alt_nburst", b_len.size() >= 3, 1);
    chk("alt_own0", qat(b_owner, 0), 0);
    chk("alt_len0", qat(b_len, 0), BL);
    chk("alt_own1", qat(b_owner, 1), 1);
    chk("alt_len1", qat(b_len, 1), BL);
    chk("alt_own2", qat(b_owner, 2), 0);

    // Only FIFO1, 5 words then empty.
    apply_reset();
    w1 = writes[1];
    push1(5); drive_inputs();
    repeat (15) step();
    chk("short_nburst", b_len.size(), 1);
    chk("short_own", qat(b_owner, 0), 1);
    chk("short_len", qat(b_len, 0), 5);
    chk("short_writes", writes[1] - w1, 5);
    chk("short_grant", grant, 0);

    // Region 0 wrap with frame-done on the region-end write.
    apply_reset();
    f0 = fd_cnt[0]; f1 = fd_cnt[1];
    push0(70); drive_inputs();
    repeat (100) step();
    chk("wrap_fd0", fd_cnt[0] - f0, 1);
    chk("wrap_fd1", fd_cnt[1] - f1, 0);

    // Flush on the 7th beat of a GRANT0 burst.
    apply_reset();
    push0(30); drive_inputs();
    for (int i = 0; i < 40 && !(grant == 2'b01 && cur_len == 6); i++) step();
    chk("flush_reach", (grant == 2'b01) && (cur_len == 6), 1);
    flush = 1'b1;
    step();
    chk("flush_beat7_rd0", s_rd0, 1);
    step();
    chk("flush_wr", s_wr, 0);
    chk("flush_rd0", s_rd0, 0);
    chk("flush_grant", s_grant, 0);
    repeat (20) step();

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    push0(30); drive_inputs();
    for (int i = 0; i < 40 && !(grant == 2'b01 && cur_len == 3); i++) step();
    chk("arst_reach", (grant == 2'b01) && (cur_len == 3), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd0", rd0, 0);
    chk("arst_wr", mem_wr, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_grant", grant, 0);
    chk("arst_fdone", {fd1, fd0}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive_inputs();
    repeat (30) step();

    // Random traffic with stalls, refills and occasional flushes.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (q0.size() < 40 && $urandom_range(0, 3) == 0) push0($urandom_range(0, 4));
      if (q1.size() < 40 && $urandom_range(0, 3) == 0) push1($urandom_range(0, 4));
      hold0 = ($urandom_range(0, 4) == 0);
      hold1 = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 399) == 0);
      drive_inputs();
    end
    hold0 = 0; hold1 = 0; drive_inputs();
    repeat (200) step();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("noloss0", writes[0], pops[0] - lost[0]);
    chk("noloss1", writes[1], pops[1] - lost[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 16, pixel word width.
REQ-002 Parameter BRAM_DEPTH, 230400, total frame-buffer words; SHALL be even; AW = $clog2(BRAM_DEPTH).
REQ-003 Parameter BURST_LEN, 16, maximum beats per grant; range 1..1024.
REQ-004 i_clk  in  1  single clock for all logic.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_flush  in  1  synchronous clear of state, counters and addresses.
REQ-007 i_almostempty0 / i_almostempty1  in  1  FIFO k has fewer than one safe word; low = ready.
REQ-008 i_rdata0 / i_rdata1  in  DATA_WIDTH  first-word-fall-through FIFO k head data.
REQ-009 o_rd0 / o_rd1  out  1  pop strobe to FIFO k.
REQ-010 o_mem_wr  out  1  BRAM write enable.
REQ-011 o_mem_waddr  out  AW  BRAM write address.
REQ-012 o_mem_wdata  out  DATA_WIDTH  BRAM write data.
REQ-013 o_grant  out  2  one-hot current owner; 00 when idle.
REQ-014 o_frame_done0 / o_frame_done1  out  1  one-cycle pulse on write of last word of region k.

Function
REQ-015 Region 0 SHALL span addresses 0..BRAM_DEPTH/2-1; region 1 SHALL span BRAM_DEPTH/2..BRAM_DEPTH-1.
REQ-016 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-017 IDLE: one requester ready -> GRANT of that requester; both ready -> GRANT of requester not equal to last_grant; none -> stay.
REQ-018 GRANTk -> IDLE when BURST_LEN beats popped or i_almostempty_k high; IDLE cycle between bursts is mandatory (1-cycle arbitration gap).
REQ-019 o_rdk SHALL equal (state==GRANTk) && !i_almostempty_k, combinational; never both high.
REQ-020 On each edge with o_rdk high: o_mem_wr<=1, o_mem_wdata<=i_rdatak, o_mem_waddr<=addr_k, addr_k advances; write latency exactly 1 cycle after pop.
REQ-021 addr_k SHALL wrap from region end to region base; o_frame_donek SHALL pulse in the same cycle o_mem_wr writes the region-end address.
REQ-022 Beat counter width $clog2(BURST_LEN+1); cleared on entry to GRANTk; last_grant updated on entry to GRANTk.
REQ-023 o_grant SHALL be registered from state (10 in GRANT1, 01 in GRANT0).
REQ-024 i_almostempty_k rising mid-burst SHALL stop popping that cycle; already-popped word still written.
REQ-025 i_flush SHALL take priority over all activity including a pending write; no write occurs the cycle after flush.
REQ-026 Non-granted requester SHALL be served within one burst plus one cycle when continuously ready (starvation-free).

Reset
REQ-027 On i_rst: state IDLE, o_mem_wr 0, o_mem_waddr 0, o_mem_wdata 0, o_grant 00, o_frame_done0/1 0, addr_0 0, addr_1 BRAM_DEPTH/2, beat counter 0, last_grant 1 (requester 0 served first).
REQ-028 i_flush SHALL load the same values as REQ-027 synchronously.
REQ-029 Reset asserted mid-burst SHALL drop o_rd0/o_rd1 immediately (asynchronously via state).

Structure
REQ-030 Shared package fb_pkg SHALL hold FSM state encoding and default DATA_WIDTH/BRAM_DEPTH/BURST_LEN constants.
REQ-031 One sub-module fb_region_counter (base, size; advance, wrap, last-address flag) SHALL be instantiated twice.
REQ-032 RTL target 120-400 lines; no memory instantiated inside this block.

Verification
REQ-033 Both FIFOs ready continuously, BURST_LEN=16 -> 16 writes region 0 (addr 0..15), 1 idle cycle, 16 writes region 1 (addr 115200..115215), alternating.
REQ-034 Only FIFO1 ready, 5 words then almostempty -> o_rd1 5 cycles, 5 writes at 115200..115204, return to IDLE, o_grant 00.
REQ-035 Preload addr_0 to 115195, FIFO0 streams 10 words -> writes 115195..115199 then 0..4, o_frame_done0 pulse exactly on write to 115199.
REQ-036 i_flush asserted during beat 7 of GRANT0 -> next cycle o_mem_wr 0, o_rd0 0, state IDLE, next burst writes from address 0.
REQ-037 i_rst asserted asynchronously mid-burst -> o_rd0 drops same cycle, all outputs match REQ-027 values before next edge.
REQ-038 Data check: FIFO0 supplies 0xA000+n, FIFO1 0xB000+n -> BRAM model contents match per region, no word lost or duplicated.
